// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the two-port memory arbiter
// Purpose: FSM state encoding, port index constants, watchdog defaults.
// Ports: none (package).
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int WDOG_W          = 5;

endpackage

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - combinational 2-way round-robin picker
// Purpose: choose which requesting port is granted, favouring the port named by ptr.
// Ports:
//   req[1:0]  - request level per port (bit n = port n)
//   ptr       - favoured port index
//   gnt_valid - at least one port is requesting
//   gnt_idx   - winning port index (meaningful only when gnt_valid)
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    if (ptr == PORT0) begin
      gnt_idx = req[0] ? PORT0 : PORT1;
    end else begin
      gnt_idx = req[1] ? PORT1 : PORT0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of one SRAM controller
// Purpose: serialise read/write requests from two ports onto one controller,
//          with a watchdog that aborts a transaction the controller never finishes.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   p{0,1}_r_en / p{0,1}_w_en     - per-port read / write request levels
//   p{0,1}_addr / p{0,1}_wdata    - per-port byte address / store data
//   p{0,1}_done                   - one-cycle completion pulse per port
//   p{0,1}_rdata                  - last read word completed for that port
//   mem_r_en / mem_w_en           - request to the controller (BUSY only)
//   mem_addr / mem_wdata          - address / store data to the controller
//   mem_rdata, mem_ready          - read word and ready from the controller
//   timeout_err                   - sticky watchdog flag
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_r_en,
  input  logic        p0_w_en,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_r_en,
  input  logic        p1_w_en,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_done,
  output logic        p1_done,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        timeout_err
);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              seen_busy_q, seen_busy_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_err_q, timeout_err_d;
  logic [31:0]       p0_rdata_q, p0_rdata_d;
  logic [31:0]       p1_rdata_q, p1_rdata_d;

  logic [1:0] req;
  logic       arb_valid;
  logic       arb_idx;

  assign req = {p1_r_en | p1_w_en, p0_r_en | p0_w_en};

  rr_arbiter2 u_rr (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    seen_busy_d   = seen_busy_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    p0_rdata_d    = p0_rdata_q;
    p1_rdata_d    = p1_rdata_q;
    mem_r_en      = 1'b0;
    mem_w_en      = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    p0_done       = 1'b0;
    p1_done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d     = BUSY;
          gnt_d       = arb_idx;
          // A port raising both r_en and w_en is treated as a write.
          wr_d        = (arb_idx == PORT1) ? p1_w_en : p0_w_en;
          addr_d      = (arb_idx == PORT1) ? p1_addr : p0_addr;
          wdata_d     = (arb_idx == PORT1) ? p1_wdata : p0_wdata;
          seen_busy_d = 1'b0;
          wdog_d      = '0;
        end
      end

      BUSY: begin
        mem_w_en  = wr_q;
        mem_r_en  = ~wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        wdog_d    = wdog_q + 1'b1;
        if (!mem_ready) begin
          seen_busy_d = 1'b1;
        end
        // The controller reports ready while idle; only a ready that follows
        // a not-ready cycle marks the end of our transaction.
        if (mem_ready && seen_busy_q) begin
          state_d = DONE;
          if (!wr_q) begin
            if (gnt_q == PORT0) begin
              p0_rdata_d = mem_rdata;
            end else begin
              p1_rdata_d = mem_rdata;
            end
          end
        end else if (wdog_d == WDOG_LIMIT) begin
          timeout_err_d = 1'b1;
          state_d       = DONE;
        end
      end

      DONE: begin
        p0_done = (gnt_q == PORT0);
        p1_done = (gnt_q == PORT1);
        ptr_d   = ~gnt_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= PORT0;
      gnt_q         <= PORT0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      seen_busy_q   <= 1'b0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      seen_busy_q   <= seen_busy_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
    end
  end

  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_r_en, p0_w_en, p1_r_en, p1_w_en;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_done, p1_done;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_r_en, mem_w_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        timeout_err;

  int err_cnt = 0;
  int chk_cnt = 0;

  // SRAM controller model: ready stays high for pre_cfg BUSY cycles, low for
  // lat_cfg cycles, then high with the result.
  int pre_cfg = 0;
  int lat_cfg = 2;
  logic [31:0] mem_model [logic [31:0]];

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .p0_r_en     (p0_r_en),
    .p0_w_en     (p0_w_en),
    .p0_addr     (p0_addr),
    .p0_wdata    (p0_wdata),
    .p1_r_en     (p1_r_en),
    .p1_w_en     (p1_w_en),
    .p1_addr     (p1_addr),
    .p1_wdata    (p1_wdata),
    .p0_done     (p0_done),
    .p1_done     (p1_done),
    .p0_rdata    (p0_rdata),
    .p1_rdata    (p1_rdata),
    .mem_r_en    (mem_r_en),
    .mem_w_en    (mem_w_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin : sram_model
    int s;
    s = 0;
    mem_ready = 1'b1;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !(mem_r_en || mem_w_en)) begin
        s = 0;
        mem_ready = 1'b1;
      end else begin
        if (s == 0) mem_rdata = 32'hBADB_AD00;
        mem_ready = !(s >= pre_cfg && s < pre_cfg + lat_cfg);
        if (s == pre_cfg + lat_cfg) begin
          if (mem_w_en) mem_model[mem_addr] = mem_wdata;
          else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr]
                                                      : (mem_addr ^ 32'hC0DE_0000);
        end
        s++;
      end
    end
  end

  task automatic wait_done(input int budget, output int port, output int cyc);
    logic found;
    found = 1'b0;
    port  = -1;
    cyc   = 0;
    for (int i = 1; i <= budget && !found; i++) begin
      @(negedge clk);
      if (p0_done || p1_done) begin
        found = 1'b1;
        cyc   = i;
        port  = (p0_done && p1_done) ? 2 : (p0_done ? 0 : 1);
      end
    end
    if (!found) check("done_seen", {31'b0, p0_done | p1_done}, 1);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_pulse"}, {30'b0, p1_done, p0_done}, 0);
    check({tag, "_gap"}, {30'b0, mem_w_en, mem_r_en}, 0);
  endtask

  initial begin : stim
    int   port, cyc;
    logic done_seen;
    rst = 1'b1;
    p0_r_en = 0; p0_w_en = 0; p0_addr = 0; p0_wdata = 0;
    p1_r_en = 0; p1_w_en = 0; p1_addr = 0; p1_wdata = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_en", {30'b0, mem_w_en, mem_r_en}, 0);
    check("rst_done", {30'b0, p1_done, p0_done}, 0);
    check("rst_p0_rdata", p0_rdata, 0);
    check("rst_p1_rdata", p1_rdata, 0);
    check("rst_timeout", {31'b0, timeout_err}, 0);
    check("rst_addr", mem_addr | mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // p0 write, lone requester
    lat_cfg = 3;
    p0_w_en = 1; p0_addr = 32'h100; p0_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t1_en", {30'b0, mem_w_en, mem_r_en}, 32'h2);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
    p0_w_en = 0;
    wait_done(40, port, cyc);
    check("t1_port", 32'(port), 0);
    check("t1_lat", 32'(cyc), 4);
    idle_check("t1");

    // p1 read back
    p1_r_en = 1; p1_addr = 32'h100;
    @(negedge clk);
    check("t2_en", {30'b0, mem_w_en, mem_r_en}, 32'h1);
    check("t2_addr", mem_addr, 32'h100);
    p1_r_en = 0;
    wait_done(40, port, cyc);
    check("t2_port", 32'(port), 1);
    check("t2_lat", 32'(cyc), 4);
    check("t2_p1_rdata", p1_rdata, 32'hDEAD_BEEF);
    check("t2_p0_rdata", p0_rdata, 0);
    idle_check("t2");

    // reset, then simultaneous held reads alternate p0, p1, p0
    rst = 1'b1;
    @(negedge clk);
    check("r2_p1_rdata", p1_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    lat_cfg = 2;
    p0_r_en = 1; p0_addr = 32'h200;
    p1_r_en = 1; p1_addr = 32'h300;
    wait_done(40, port, cyc);
    check("t3a_port", 32'(port), 0);
    check("t3a_lat", 32'(cyc), 4);
    check("t3a_p0_rdata", p0_rdata, 32'hC0DE_0200);
    p0_addr = 32'h204;
    idle_check("t3a");
    wait_done(40, port, cyc);
    check("t3b_port", 32'(port), 1);
    check("t3b_lat", 32'(cyc), 4);
    check("t3b_p1_rdata", p1_rdata, 32'hC0DE_0300);
    check("t3b_p0_rdata", p0_rdata, 32'hC0DE_0200);
    idle_check("t3b");
    wait_done(40, port, cyc);
    check("t3c_port", 32'(port), 0);
    check("t3c_p0_rdata", p0_rdata, 32'hC0DE_0204);
    p0_r_en = 0; p1_r_en = 0;
    idle_check("t3c");

    // r_en and w_en together is a write
    p0_r_en = 1; p0_w_en = 1; p0_addr = 32'h400; p0_wdata = 32'h1234_5678;
    @(negedge clk);
    check("t4_en", {30'b0, mem_w_en, mem_r_en}, 32'h2);
    p0_r_en = 0; p0_w_en = 0;
    wait_done(40, port, cyc);
    check("t4_port", 32'(port), 0);
    check("t4_lat", 32'(cyc), 3);
    check("t4_p0_rdata", p0_rdata, 32'hC0DE_0204);
    check("t4_p1_rdata", p1_rdata, 32'hC0DE_0300);
    idle_check("t4");

    // controller idle-ready in the first BUSY cycle must be ignored
    pre_cfg = 1; lat_cfg = 2;
    p1_r_en = 1; p1_addr = 32'h400;
    @(negedge clk);
    check("t5_en", {30'b0, mem_w_en, mem_r_en}, 32'h1);
    p1_r_en = 0;
    wait_done(40, port, cyc);
    check("t5_port", 32'(port), 1);
    check("t5_lat", 32'(cyc), 4);
    check("t5_p1_rdata", p1_rdata, 32'h1234_5678);
    idle_check("t5");
    pre_cfg = 0;

    // watchdog: controller stalls 20 cycles, limit 16
    lat_cfg = 20;
    p1_r_en = 1; p1_addr = 32'h500;
    @(negedge clk);
    check("t6_pre_to", {31'b0, timeout_err}, 0);
    p1_r_en = 0;
    wait_done(40, port, cyc);
    check("t6_port", 32'(port), 1);
    check("t6_lat", 32'(cyc), 16);
    check("t6_to", {31'b0, timeout_err}, 1);
    check("t6_p1_rdata", p1_rdata, 32'h1234_5678);
    idle_check("t6");

    // flag stays set through a normal transaction
    lat_cfg = 2;
    p0_r_en = 1; p0_addr = 32'h600;
    @(negedge clk);
    p0_r_en = 0;
    wait_done(40, port, cyc);
    check("t7_port", 32'(port), 0);
    check("t7_lat", 32'(cyc), 3);
    check("t7_p0_rdata", p0_rdata, 32'hC0DE_0600);
    check("t7_to", {31'b0, timeout_err}, 1);
    idle_check("t7");

    // reset in mid-BUSY; afterwards port 0 is favoured again
    lat_cfg = 5;
    p1_w_en = 1; p1_addr = 32'h700; p1_wdata = 32'h77;
    @(negedge clk);
    check("t8_en", {30'b0, mem_w_en, mem_r_en}, 32'h2);
    p1_w_en = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t8_rst_en", {30'b0, mem_w_en, mem_r_en}, 0);
    check("t8_rst_addr", mem_addr, 0);
    check("t8_rst_to", {31'b0, timeout_err}, 0);
    check("t8_rst_p0_rdata", p0_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      done_seen = done_seen | p0_done | p1_done | mem_w_en | mem_r_en;
    end
    check("t8_quiet", {31'b0, done_seen}, 0);
    lat_cfg = 2;
    p0_r_en = 1; p0_addr = 32'h800;
    p1_r_en = 1; p1_addr = 32'h900;
    wait_done(40, port, cyc);
    check("t8a_port", 32'(port), 0);
    check("t8a_lat", 32'(cyc), 4);
    check("t8a_p0_rdata", p0_rdata, 32'hC0DE_0800);
    p0_r_en = 0;
    idle_check("t8a");
    wait_done(40, port, cyc);
    check("t8b_port", 32'(port), 1);
    check("t8b_p1_rdata", p1_rdata, 32'hC0DE_0900);
    p1_r_en = 0;
    idle_check("t8b");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum number of BUSY cycles before a watchdog error.
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst, input, 1, reset; rst is asynchronous and active-high, and the clock is clk.
REQ-004 SHALL have ports p0_r_en and p0_w_en, input, 1 each, port-0 read and write request levels.
REQ-005 SHALL have ports p0_addr and p0_wdata, input, 32 each, port-0 byte address and store data.
REQ-006 SHALL have ports p1_r_en, p1_w_en, p1_addr and p1_wdata, with the same widths and meanings as port 0.
REQ-007 SHALL have ports p0_done and p1_done, output, 1 each, one-cycle completion pulse per port.
REQ-008 SHALL have ports p0_rdata and p1_rdata, output, 32 each, last read word completed for that port.
REQ-009 SHALL have ports mem_r_en and mem_w_en, output, 1 each, request to the SRAM controller.
REQ-010 SHALL have ports mem_addr and mem_wdata, output, 32 each, address and store data to the SRAM controller.
REQ-011 SHALL have port mem_rdata, input, 32, read word from the SRAM controller.
REQ-012 SHALL have port mem_ready, input, 1, controller ready; low while a transaction is in progress.
REQ-013 SHALL have port timeout_err, output, 1, sticky watchdog flag.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-015 In IDLE, with a request pending on any port, SHALL pick the winner by 2-way round-robin, latch the port index, op, addr and wdata, and go to BUSY next cycle.
REQ-016 With no request pending, SHALL remain in IDLE with mem_r_en=mem_w_en=0.
REQ-017 The round-robin pointer SHALL favour the port not served last; after reset it SHALL favour port 0.
REQ-018 If one port asserts r_en and w_en together, it SHALL be served as a write.
REQ-019 In BUSY, SHALL drive mem_addr and mem_wdata from the latched values and exactly one of mem_w_en/mem_r_en from the latched op; outside BUSY both enables SHALL be 0 and addr/wdata SHALL be 0.
REQ-020 SHALL set a seen_busy flag on any BUSY cycle with mem_ready=0; the flag SHALL be cleared on entry to BUSY.
REQ-021 Completion SHALL be BUSY with mem_ready=1 and seen_busy=1; a mem_ready=1 seen before seen_busy is set (the controller's idle ready) SHALL be ignored.
REQ-022 On completion of a read, SHALL register mem_rdata into the granted port's rdata; the other port's rdata SHALL be unchanged.
REQ-023 On completion SHALL go to DONE; a write completion SHALL leave both rdata outputs unchanged.
REQ-024 In DONE, SHALL pulse the granted port's done for exactly one cycle, toggle the pointer to the other port and return to IDLE.
REQ-025 Latency SHALL be: request in IDLE at cycle t, enable asserted at t+1, done at completion+1; an idle bus SHALL never issue back to back without an IDLE cycle between transactions.
REQ-026 A requester SHALL be served again if its request is still asserted in the IDLE cycle after its done pulse.
REQ-027 Requests arriving while BUSY or DONE SHALL wait; they SHALL NOT be lost or reordered by the arbiter.
REQ-028 A 5-bit watchdog counter SHALL clear on BUSY entry and increment each BUSY cycle.
REQ-029 When the watchdog count reaches TIMEOUT, SHALL set timeout_err (sticky until reset), go to DONE and pulse done with rdata unchanged.
REQ-030 Address and data SHALL be passed through unmodified; word splitting is the controller's responsibility.

Reset
REQ-031 On rst, asynchronously: state=IDLE, pointer=port 0, seen_busy=0, watchdog=0, latched regs=0.
REQ-032 On rst, asynchronously: all outputs 0, including p0_rdata, p1_rdata and timeout_err.
REQ-033 Reset mid-BUSY SHALL drop enables immediately and produce no done pulse; the controller shares rst.

Structure
REQ-034 A shared package SHALL hold the state encodings (2 bits), the port index constants PORT0=0 and PORT1=1, and the default TIMEOUT.
REQ-035 The round-robin picker SHALL be a separate sub-module rr_arbiter2: inputs req[1:0] and ptr; outputs gnt_valid and gnt_idx; combinational.

Verification
REQ-036 p0 write addr=0x100 data=0xDEADBEEF alone -> mem_w_en high from t+1, p0_done one pulse after mem_ready returns high, p1_done stays 0.
REQ-037 p1 read addr=0x100 after the above, model returns 0xDEADBEEF -> p1_rdata=0xDEADBEEF at done, p0_rdata unchanged.
REQ-038 p0 and p1 read asserted the same cycle after reset -> p0 served first, then p1; held requests alternate p0, p1, p0.
REQ-039 Model holds mem_ready low for 20 cycles, TIMEOUT=16 -> timeout_err=1 after 16 BUSY cycles, done pulses, and the flag stays set.
REQ-040 rst asserted in mid-BUSY -> enables 0 the same cycle, no done pulse, and the next request is served normally with port 0 favoured.
REQ-041 p0 r_en and w_en asserted together -> mem_w_en=1 and mem_r_en=0.
